// File: rtl/chan_fifo_packer.sv
// Frames decimated rx I/Q samples into {header, timestamp, payload} packets using ping-pong payload banks.
// Latency: the header word appears two cycles after a bank closes, provided the FIFO has room for the whole packet.
// Backpressure: a packet waits in SPACE until space_avail covers it; samples are dropped (sticky overrun) when both banks are full.
module chan_fifo_packer #(
   parameter int PAYLOAD_MAX = 126,
   parameter int CHAN        = 0
) (
   input  logic        rx_clock,
   input  logic        reset,
   input  logic        rx_strobe,
   input  logic [15:0] rx_i,
   input  logic [15:0] rx_q,
   input  logic [31:0] timestamp_clock,
   input  logic        enable,
   input  logic [31:0] rssi,
   input  logic [31:0] threshhold,
   input  logic [8:0]  space_avail,
   output logic [31:0] fifodata,
   output logic        wrreq,
   output logic        pkt_done,
   output logic        overrun,
   output logic [14:0] debug
);

   typedef enum logic [2:0] {
      S_IDLE, S_SPACE, S_HEADER, S_TSTAMP, S_PAYLOAD, S_DONE
   } state_t;

   localparam logic [6:0] PMAX    = 7'(PAYLOAD_MAX);
   localparam logic [4:0] CHAN_ID = 5'(CHAN);

   logic [31:0] mem [0:1][0:PAYLOAD_MAX-1];

   // fill side state
   logic        fill_bank;
   logic [6:0]  fill_cnt;
   logic [1:0]  bank_full;
   logic [6:0]  bank_len [0:1];
   logic [31:0] bank_ts  [0:1];
   logic [1:0]  bank_sob, bank_eob, bank_rssi;
   logic        enable_d, burst_active, sob_pending;

   // drain side state
   state_t      packer_state;
   logic        drain_bank;
   logic [6:0]  drain_len;
   logic [6:0]  rd_idx;

   logic        drain_release, other_free, swap, cur_bank, cur_full;
   logic [6:0]  cur_cnt, cnt_next;
   logic        rise, fall, accept, drop, close_full, close_eob, eob_late, do_close;

   // Resolve which bank a sample lands in this cycle; a full fill bank hands over
   // to the other bank the moment that one is (or is becoming) empty.
   always_comb begin
      drain_release = (packer_state == S_DONE);
      other_free    = !bank_full[~fill_bank] || (drain_release && (drain_bank == ~fill_bank));
      swap          = bank_full[fill_bank] && other_free;
      cur_bank      = swap ? ~fill_bank : fill_bank;
      cur_cnt       = swap ? 7'd0 : fill_cnt;
      cur_full      = swap ? 1'b0 : bank_full[fill_bank];
      rise          = enable && !enable_d;
      fall          = !enable && enable_d;
      accept        = rx_strobe && enable && !cur_full;
      drop          = rx_strobe && enable && cur_full;
      cnt_next      = cur_cnt + {6'd0, accept};
      close_full    = accept && (cnt_next == PMAX);
      close_eob     = fall && burst_active && !cur_full;
      // Burst ends while the fill bank is already closed and queued: tag that packet as EOB.
      eob_late      = fall && burst_active && cur_full;
      do_close      = close_full || close_eob;
   end

   // Payload storage; only a bank that is not full is ever written.
   always_ff @(posedge rx_clock) begin
      if (accept) mem[cur_bank][cur_cnt] <= {rx_q, rx_i};
   end

   // Fill side: burst tracking, packet close, bank ownership and overrun.
   always_ff @(posedge rx_clock or negedge reset) begin
      if (!reset) begin
         fill_bank    <= 1'b0;
         fill_cnt     <= '0;
         bank_full    <= '0;
         bank_len     <= '{default: '0};
         bank_ts      <= '{default: '0};
         bank_sob     <= '0;
         bank_eob     <= '0;
         bank_rssi    <= '0;
         enable_d     <= 1'b0;
         burst_active <= 1'b0;
         sob_pending  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         enable_d  <= enable;
         fill_bank <= cur_bank;
         fill_cnt  <= cnt_next;
         if (rise) begin
            burst_active <= 1'b1;
            sob_pending  <= 1'b1;
            overrun      <= 1'b0;
         end
         if (fall) burst_active <= 1'b0;
         if (drop) overrun <= 1'b1;
         if (drain_release) bank_full[drain_bank] <= 1'b0;
         if (accept && (cur_cnt == 7'd0)) bank_ts[cur_bank] <= timestamp_clock;
         if (eob_late) bank_eob[cur_bank] <= 1'b1;
         if (do_close) begin
            bank_full[cur_bank] <= 1'b1;
            bank_len[cur_bank]  <= cnt_next;
            bank_sob[cur_bank]  <= sob_pending;
            bank_eob[cur_bank]  <= close_eob;
            bank_rssi[cur_bank] <= (rssi > threshhold);
            sob_pending         <= 1'b0;
            fill_cnt            <= '0;
            if (cnt_next == 7'd0) bank_ts[cur_bank] <= timestamp_clock;
            if (!swap && other_free) fill_bank <= ~cur_bank;
         end
      end
   end

   // Drain FSM: emits header, timestamp and payload back to back, then pulses pkt_done.
   always_ff @(posedge rx_clock or negedge reset) begin
      if (!reset) begin
         packer_state <= S_IDLE;
         drain_bank   <= 1'b0;
         drain_len    <= '0;
         rd_idx       <= '0;
         fifodata     <= '0;
         wrreq        <= 1'b0;
         pkt_done     <= 1'b0;
      end else begin
         case (packer_state)
            S_IDLE: begin
               wrreq    <= 1'b0;
               pkt_done <= 1'b0;
               if (|bank_full) begin
                  // When both banks are full the non-fill bank closed first.
                  drain_bank   <= bank_full[~fill_bank] ? ~fill_bank : fill_bank;
                  packer_state <= S_SPACE;
               end
            end
            S_SPACE: begin
               if (({2'b00, bank_len[drain_bank]} + 9'd2) <= space_avail) begin
                  fifodata     <= {3'b000, bank_sob[drain_bank], bank_eob[drain_bank],
                                   bank_rssi[drain_bank], 5'd0, CHAN_ID, 7'd0,
                                   bank_len[drain_bank], 2'b00};
                  wrreq        <= 1'b1;
                  drain_len    <= bank_len[drain_bank];
                  packer_state <= S_HEADER;
               end
            end
            S_HEADER: begin
               fifodata     <= bank_ts[drain_bank];
               packer_state <= S_TSTAMP;
            end
            S_TSTAMP: begin
               if (drain_len == 7'd0) begin
                  wrreq        <= 1'b0;
                  pkt_done     <= 1'b1;
                  packer_state <= S_DONE;
               end else begin
                  fifodata     <= mem[drain_bank][0];
                  rd_idx       <= 7'd1;
                  packer_state <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (rd_idx == drain_len) begin
                  wrreq        <= 1'b0;
                  pkt_done     <= 1'b1;
                  packer_state <= S_DONE;
               end else begin
                  fifodata <= mem[drain_bank][rd_idx];
                  rd_idx   <= rd_idx + 7'd1;
               end
            end
            S_DONE: begin
               pkt_done     <= 1'b0;
               packer_state <= S_IDLE;
            end
            default: packer_state <= S_IDLE;
         endcase
      end
   end

   assign debug = {6'd0, wrreq, pkt_done, overrun, 3'(packer_state), enable, rx_strobe, rx_clock};

endmodule
